conversor_bcd: RTL and testbench

- Sequential binary-to-BCD converter directly downstream of the sign-magnitude arithmetic stage.
- Captures the 20-bit magnitude `resultado` and its sign `signo_resultado` on a start pulse, then converts them with iterative double-dabble (shift-add-3).
- Presents 7 BCD digits, a cleaned sign and a significant-digit count to the display multiplexer.
- 20-bit width covers the full 1023×1023 product planned for oper 2.

---
 rtl/calc_pkg.sv | 16 +
 rtl/bcd_add3.sv | 12 +
 rtl/conversor_bcd.sv | 139 +++++++++++++
 tb/tb_conversor_bcd.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared widths and FSM encoding for the arithmetic, BCD conversion and display stages.
package calc_pkg;

  localparam int unsigned W_BIN  = 20;                 // magnitude width / shift iterations
  localparam int unsigned N_DIG  = 7;                  // BCD digits, 10^N_DIG > 2^W_BIN - 1
  localparam int unsigned W_BCD  = 4 * N_DIG;
  localparam int unsigned W_CNT  = $clog2(W_BIN + 1);
  localparam int unsigned W_NDIG = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // Per-nibble correction, no carry out.
  always_comb begin
    d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
  end

endmodule

// File: rtl/conversor_bcd.sv
// Sequential binary-to-BCD converter (iterative shift-add-3) feeding the display multiplexer.
module conversor_bcd
  import calc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [W_BIN-1:0]   bin,
  input  logic               sign_in,
  output logic               busy,
  output logic               done,
  output logic [W_BCD-1:0]   bcd,
  output logic               sign_out,
  output logic [W_NDIG-1:0]  ndig
);

  state_e             state_q, state_d;
  logic [W_BIN-1:0]   shreg_q, shreg_d;
  logic [W_BCD-1:0]   scr_q, scr_d;
  logic [W_CNT-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [W_BCD-1:0]   bcd_q, bcd_d;
  logic               sign_out_q, sign_out_d;
  logic [W_NDIG-1:0]  ndig_q, ndig_d;

  logic [W_BCD-1:0]         scr_adj;
  logic [W_BCD-1:0]         scr_sh;
  logic [W_BIN-1:0]         shreg_sh;
  logic [W_BCD+W_BIN-1:0]   cat_sh;
  logic [W_NDIG-1:0]        ndig_enc;
  logic                     last_iter;

  assign last_iter = (cnt_q == W_CNT'(W_BIN - 1));

  // Add-3 correction on every scratch digit before the shift.
  for (genvar g = 0; g < N_DIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (scr_q[4*g +: 4]),
      .d_o (scr_adj[4*g +: 4])
    );
  end

  // Shift {scratch, shreg} left by one; the magnitude MSB enters the units digit.
  always_comb begin
    cat_sh   = {scr_adj, shreg_q} << 1;
    scr_sh   = cat_sh[W_BCD+W_BIN-1 -: W_BCD];
    shreg_sh = cat_sh[W_BIN-1:0];
  end

  // Significant-digit count of the post-shift scratch: highest non-zero digit + 1, at least 1.
  always_comb begin
    ndig_enc = W_NDIG'(1);
    for (int i = 1; i < int'(N_DIG); i++) begin
      if (scr_sh[4*i +: 4] != 4'd0) ndig_enc = W_NDIG'(i + 1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; start outside IDLE is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (last_iter) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy while shifting, done for the single DONE cycle.
  always_comb begin
    busy = (state_q == ST_SHIFT);
    done = (state_q == ST_DONE);
  end

  // Datapath next-state: capture on accept, iterate in SHIFT, publish results on the last iteration.
  always_comb begin
    shreg_d    = shreg_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    bcd_d      = bcd_q;
    sign_out_d = sign_out_q;
    ndig_d     = ndig_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d = bin;
          sign_d  = sign_in;
          scr_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        shreg_d = shreg_sh;
        scr_d   = scr_sh;
        cnt_d   = cnt_q + W_CNT'(1);
        if (last_iter) begin
          bcd_d      = scr_sh;
          // A zero magnitude has an all-zero BCD result, so this clears negative zero.
          sign_out_d = sign_q & (|scr_sh);
          ndig_d     = ndig_enc;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q    <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      bcd_q      <= '0;
      sign_out_q <= 1'b0;
      ndig_q     <= W_NDIG'(1);
    end else begin
      shreg_q    <= shreg_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      bcd_q      <= bcd_d;
      sign_out_q <= sign_out_d;
      ndig_q     <= ndig_d;
    end
  end

  assign bcd      = bcd_q;
  assign sign_out = sign_out_q;
  assign ndig     = ndig_q;

endmodule

// File: tb/tb_conversor_bcd.sv
// Self-checking bench for conversor_bcd: decimal reference model plus directed literal checks.
module tb_conversor_bcd;
  import calc_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [W_BIN-1:0]  bin = '0;
  logic              sign_in = 1'b0;
  logic              busy, done, sign_out;
  logic [W_BCD-1:0]  bcd;
  logic [W_NDIG-1:0] ndig;

  int n_cmp = 0;
  int n_bad = 0;

  conversor_bcd dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .sign_in  (sign_in),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .sign_out (sign_out),
    .ndig     (ndig)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division.
  function automatic logic [W_BCD-1:0] to_bcd(input int unsigned v);
    logic [W_BCD-1:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < int'(N_DIG); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int unsigned dec_digits(input int unsigned v);
    int unsigned n, t;
    n = 1;
    t = v;
    while (t >= 10) begin
      t = t / 10;
      n++;
    end
    return n;
  endfunction

  // Behavioural model: phase 0 idle, 1 converting, 2 result cycle.
  int               m_phase = 0;
  int               m_iter = 0;
  int unsigned      m_bin = 0;
  logic             m_sign = 1'b0;
  logic [W_BCD-1:0] e_bcd = '0;
  logic             e_sign = 1'b0;
  int unsigned      e_ndig = 1;
  bit               armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_iter  = 0;
      e_bcd   = '0;
      e_sign  = 1'b0;
      e_ndig  = 1;
      armed   = 1'b1;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_bin   = int'(bin);
          m_sign  = sign_in;
          m_iter  = 0;
          m_phase = 1;
        end
        1: begin
          m_iter++;
          if (m_iter == int'(W_BIN)) begin
            m_phase = 2;
            e_bcd   = to_bcd(m_bin);
            e_sign  = m_sign && (m_bin != 0);
            e_ndig  = dec_digits(m_bin);
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      n_cmp++;
      if (busy !== (m_phase == 1) || done !== (m_phase == 2) || bcd !== e_bcd ||
          sign_out !== e_sign || ndig !== W_NDIG'(e_ndig)) begin
        n_bad++;
        $display("FAIL model t=%0t busy=%b/%b done=%b/%b bcd=%h/%h sign=%b/%b ndig=%0d/%0d",
                 $time, busy, (m_phase == 1), done, (m_phase == 2), bcd, e_bcd,
                 sign_out, e_sign, ndig, e_ndig);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Steps until done is seen; n is the number of edges taken. Bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout got=no_done want=done");
    end
  endtask

  task automatic convert(input int unsigned v, input logic s, output int n);
    bin     = W_BIN'(v);
    sign_in = s;
    start   = 1'b1;
    step();
    start   = 1'b0;
    wait_done(n);
  endtask

  int n;

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_bcd", longint'(bcd), 0);
    chk("reset_ndig", longint'(ndig), 1);
    chk("reset_busy", longint'(busy), 0);

    // Zero with negative sign: sign is cleaned.
    convert(0, 1'b1, n);
    chk("zero_latency", n, 20);
    chk("zero_bcd", longint'(bcd), 0);
    chk("zero_sign", longint'(sign_out), 0);
    chk("zero_ndig", longint'(ndig), 1);
    step();

    convert(2046, 1'b0, n);
    chk("b2046_bcd", longint'(bcd), 'h0002046);
    chk("b2046_ndig", longint'(ndig), 4);
    step();
    chk("b2046_done_width", longint'(done), 0);

    convert(1048575, 1'b1, n);
    chk("max_bcd", longint'(bcd), 'h1048575);
    chk("max_sign", longint'(sign_out), 1);
    chk("max_ndig", longint'(ndig), 7);
    step();

    convert(1046529, 1'b0, n);
    chk("b1046529_bcd", longint'(bcd), 'h1046529);
    step();

    // Start during SHIFT is ignored and input changes are not seen.
    bin = W_BIN'(37);
    sign_in = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    bin = W_BIN'(999);
    start = 1'b1;
    step();
    start = 1'b0;
    bin = W_BIN'(5);
    wait_done(n);
    chk("ignored_start_bcd", longint'(bcd), 'h0000037);
    step();
    step();
    chk("no_queued_start", longint'(busy), 0);
    convert(999, 1'b0, n);
    chk("b999_bcd", longint'(bcd), 'h0000999);
    chk("b999_ndig", longint'(ndig), 3);
    step();

    // Reset mid-conversion discards it.
    bin = W_BIN'(777);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_bcd", longint'(bcd), 0);
    repeat (25) step();
    convert(512, 1'b0, n);
    chk("b512_latency", n, 20);
    chk("b512_bcd", longint'(bcd), 'h0000512);
    step();

    // start held high: one result every W_BIN+2 cycles.
    bin = W_BIN'(100);
    sign_in = 1'b0;
    start = 1'b1;
    wait_done(n);
    for (int k = 0; k < 3; k++) begin
      step();
      wait_done(n);
      chk("period", n + 1, 22);
      chk("held_bcd", longint'(bcd), 'h0000100);
    end
    start = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
